// File: rtl/agg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : agg_pkg
// Description : Shared constants and helper functions for stream_aggregator.
//               clamp_fetch() maps a run-time lane request onto 1..MAX and
//               thermo_mask() builds a lane-valid thermometer mask.
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
package agg_pkg;

    localparam int c_DEF_DATA_WIDTH      = 11;
    localparam int c_DEF_MAX_FETCH_WIDTH = 4;
    // Widest mask thermo_mask() can produce; callers slice their own width.
    localparam int c_MASK_MAX_W          = 32;

    // A request of 0 or anything above the maximum selects the maximum.
    function automatic int clamp_fetch(input int cfg, input int max_fetch);
        if ((cfg == 0) || (cfg > max_fetch)) begin
            return max_fetch;
        end
        return cfg;
    endfunction

    // Bits [n-1:0] set, everything above cleared.
    function automatic logic [c_MASK_MAX_W-1:0] thermo_mask(input int n);
        logic [c_MASK_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < c_MASK_MAX_W; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/agg_lane_buffer.sv
`default_nettype none
// ============================================================================
// Module      : agg_lane_buffer
// Description : Accumulator stage of the stream aggregator. Holds the partial
//               group, the lane counter and the group size latched at the
//               start of each group. Word k of a group lands in lane k.
// Macros      : none
// Revision    : 1.0 - initial release
// ============================================================================
module agg_lane_buffer
    import agg_pkg::*;
#(
    parameter int DATA_WIDTH      = c_DEF_DATA_WIDTH,
    parameter int MAX_FETCH_WIDTH = c_DEF_MAX_FETCH_WIDTH,
    parameter int CNT_W           = $clog2(MAX_FETCH_WIDTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_wr,
    input  logic [DATA_WIDTH-1:0]                 i_word,
    input  logic [CNT_W-1:0]                      i_cfg_fetch,
    input  logic                                  i_clear,
    output logic [CNT_W-1:0]                      o_fetch,
    output logic [CNT_W-1:0]                      o_count,
    output logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] o_acc,
    output logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] o_group_data,
    output logic                                  o_last
);

    logic [CNT_W-1:0]                      r_count;
    logic [CNT_W-1:0]                      r_cur_fetch;
    logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] r_acc;
    logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] w_acc_wr;
    logic [CNT_W-1:0]                      w_fetch;
    logic                                  w_last;

    // Between groups the live configuration applies, so the first word of a
    // group already sees a new lane count; inside a group it is frozen.
    assign w_fetch = (r_count == '0) ? i_cfg_fetch : r_cur_fetch;
    assign w_last  = i_wr && (r_count == (w_fetch - CNT_W'(1)));

    // Lane-write demux: the incoming word is merged into lane r_count.
    always_comb begin
        w_acc_wr = r_acc;
        for (int i = 0; i < MAX_FETCH_WIDTH; i++) begin
            if (i_wr && (r_count == CNT_W'(i))) begin
                w_acc_wr[i*DATA_WIDTH +: DATA_WIDTH] = i_word;
            end
        end
    end

    // Accumulate words; wipe the buffer once its contents move to the output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_cur_fetch <= i_cfg_fetch;
        end else begin
            r_cur_fetch <= w_fetch;
            if (w_last || i_clear) begin
                r_acc   <= '0;
                r_count <= '0;
            end else if (i_wr) begin
                r_acc   <= w_acc_wr;
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_fetch      = w_fetch;
    assign o_count      = r_count;
    assign o_acc        = r_acc;
    assign o_group_data = w_acc_wr;
    assign o_last       = w_last;

endmodule
`default_nettype wire

// File: rtl/stream_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : stream_aggregator
// Description : Packs DATA_WIDTH words from a FIFO-style sender into words of
//               up to MAX_FETCH_WIDTH lanes with a thermometer lane mask.
//               Accumulator (agg_lane_buffer) feeds a one-entry output slot
//               that can drain and refill in the same cycle.
// Macros      : AGG_FLUSH_EN - enables the flush input, which emits a
//               partially filled group. Without it flush is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_aggregator
    import agg_pkg::*;
#(
    parameter int DATA_WIDTH      = c_DEF_DATA_WIDTH,
    parameter int MAX_FETCH_WIDTH = c_DEF_MAX_FETCH_WIDTH,
    parameter int CNT_W           = $clog2(MAX_FETCH_WIDTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CNT_W-1:0]                      cfg_fetch_count,
    input  logic [DATA_WIDTH-1:0]                 sender_data,
    input  logic                                  sender_empty_n,
    output logic                                  sender_deq,
    output logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] receiver_data,
    output logic [MAX_FETCH_WIDTH-1:0]            receiver_mask,
    input  logic                                  receiver_full_n,
    output logic                                  receiver_enq,
    input  logic                                  flush,
    output logic                                  busy
);

    localparam logic [1:0] c_S_IDLE       = 2'd0;
    localparam logic [1:0] c_S_ACCUM      = 2'd1;
    localparam logic [1:0] c_S_FLUSH_PEND = 2'd2;

    logic [1:0]                            r_state;
    logic [1:0]                            w_state_nxt;
    logic                                  r_out_valid;
    logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] r_out_data;
    logic [MAX_FETCH_WIDTH-1:0]            r_out_mask;

    logic                                  w_slot_free;
    logic                                  w_deq;
    logic                                  w_enq;
    logic                                  w_last;
    logic                                  w_flush_pend;
    logic                                  w_flush_set;
    logic                                  w_flush_load;
    logic [CNT_W-1:0]                      w_cfg_clamped;
    logic [CNT_W-1:0]                      w_fetch;
    logic [CNT_W-1:0]                      w_count;
    logic [CNT_W-1:0]                      w_mask_n;
    logic [c_MASK_MAX_W-1:0]               w_mask_wide;
    logic [MAX_FETCH_WIDTH-1:0]            w_mask;
    logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] w_acc;
    logic [MAX_FETCH_WIDTH*DATA_WIDTH-1:0] w_group_data;

    assign w_cfg_clamped = CNT_W'(clamp_fetch(int'(cfg_fetch_count), MAX_FETCH_WIDTH));

    // Handshakes: the slot frees up in the same cycle it is drained, so a
    // full-rate stream never sees a bubble.
    assign w_slot_free = !r_out_valid || receiver_full_n;
    assign w_deq       = !rst && sender_empty_n && w_slot_free && !w_flush_pend;
    assign w_enq       = !rst && r_out_valid && receiver_full_n;

`ifdef AGG_FLUSH_EN
    assign w_flush_pend = (r_state == c_S_FLUSH_PEND);
    // A flush that coincides with group completion is absorbed by that group.
    assign w_flush_set  = flush && ((w_count != '0) || w_deq) && !w_last && !w_flush_pend;
`else
    logic w_unused_flush;
    assign w_unused_flush = flush;
    assign w_flush_pend   = 1'b0;
    assign w_flush_set    = 1'b0;
`endif

    assign w_flush_load = w_flush_pend && w_slot_free;

    // Partial groups take the lane count reached so far, full groups the group size.
    assign w_mask_n    = w_flush_load ? w_count : w_fetch;
    assign w_mask_wide = thermo_mask(int'(w_mask_n));
    assign w_mask      = w_mask_wide[MAX_FETCH_WIDTH-1:0];

    generate
        if (MAX_FETCH_WIDTH < c_MASK_MAX_W) begin : g_mask_tail
            logic w_unused_mask_tail;
            assign w_unused_mask_tail = ^w_mask_wide[c_MASK_MAX_W-1:MAX_FETCH_WIDTH];
        end
    endgenerate

    agg_lane_buffer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .MAX_FETCH_WIDTH (MAX_FETCH_WIDTH),
        .CNT_W           (CNT_W)
    ) u_lane_buffer (
        .clk          (clk),
        .rst          (rst),
        .i_wr         (w_deq),
        .i_word       (sender_data),
        .i_cfg_fetch  (w_cfg_clamped),
        .i_clear      (w_flush_load),
        .o_fetch      (w_fetch),
        .o_count      (w_count),
        .o_acc        (w_acc),
        .o_group_data (w_group_data),
        .o_last       (w_last)
    );

    // Group-level state: idle, accumulating, or waiting to push a partial group.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE, c_S_ACCUM: begin
                if (w_flush_set) begin
                    w_state_nxt = c_S_FLUSH_PEND;
                end else if (w_last) begin
                    w_state_nxt = c_S_IDLE;
                end else if (w_deq) begin
                    w_state_nxt = c_S_ACCUM;
                end
            end
            c_S_FLUSH_PEND: begin
                if (w_slot_free) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // State register for the group FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output slot: load a completed or flushed group, release it on enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
        end else if (w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_group_data;
            r_out_mask  <= w_mask;
        end else if (w_flush_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc;
            r_out_mask  <= w_mask;
        end else if (w_enq) begin
            r_out_valid <= 1'b0;
        end
    end

    assign sender_deq    = w_deq;
    assign receiver_enq  = w_enq;
    assign receiver_data = r_out_data;
    assign receiver_mask = r_out_mask;
    assign busy          = (w_count != '0) || r_out_valid || w_flush_pend;

endmodule
`default_nettype wire

// File: tb/tb_stream_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_aggregator
// Description : Self-checking bench for stream_aggregator. Expected output
//               words are queued before each stream is driven and popped as
//               the DUT enqueues. Flush checks follow AGG_FLUSH_EN.
// Macros      : AGG_FLUSH_EN - selects the flush-enabled expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_aggregator;

    localparam int DW     = 11;
    localparam int MF     = 4;
    localparam int CW     = 3;
    localparam int BUDGET = 400;

    logic            clk = 1'b0;
    logic            rst;
    logic [CW-1:0]   cfg_fetch_count;
    logic [DW-1:0]   sender_data;
    logic            sender_empty_n;
    logic            sender_deq;
    logic [MF*DW-1:0] receiver_data;
    logic [MF-1:0]   receiver_mask;
    logic            receiver_full_n;
    logic            receiver_enq;
    logic            flush;
    logic            busy;

    int total    = 0;
    int bad      = 0;
    int enq_seen = 0;
    int enq0;
    int wcyc;

    typedef struct {
        logic [MF*DW-1:0] data;
        logic [MF-1:0]    mask;
    } exp_t;

    typedef struct {
        int            cfg;
        int            base;
        int            n;
        int            stall;
        int            full;
        logic [MF-1:0] mask;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    exp_t e;

    stream_aggregator #(
        .DATA_WIDTH      (DW),
        .MAX_FETCH_WIDTH (MF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_fetch_count (cfg_fetch_count),
        .sender_data     (sender_data),
        .sender_empty_n  (sender_empty_n),
        .sender_deq      (sender_deq),
        .receiver_data   (receiver_data),
        .receiver_mask   (receiver_mask),
        .receiver_full_n (receiver_full_n),
        .receiver_enq    (receiver_enq),
        .flush           (flush),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    function automatic int clampf(input int c);
        return ((c == 0) || (c > MF)) ? MF : c;
    endfunction

    // Expected word whose lanes hold w0, w0+1, ... for fc lanes.
    function automatic exp_t mk(input int fc, input int w0);
        exp_t x;
        x.data = '0;
        x.mask = '0;
        for (int i = 0; i < fc; i++) begin
            x.data[i*DW +: DW] = DW'(w0 + i);
            x.mask[i]          = 1'b1;
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Called #1 after a negedge: compares any enqueue about to commit.
    task automatic sample();
        exp_t x;
        if (receiver_enq) begin
            enq_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL enq_unexpected: got data=%0h mask=%b required no enq",
                         receiver_data, receiver_mask);
            end else begin
                x = exp_q.pop_front();
                if ((receiver_data !== x.data) || (receiver_mask !== x.mask)) begin
                    bad++;
                    $display("FAIL enq_word: got data=%0h mask=%b required data=%0h mask=%b",
                             receiver_data, receiver_mask, x.data, x.mask);
                end
            end
        end
        if (sender_deq && !sender_empty_n) begin
            total++;
            bad++;
            $display("FAIL deq_when_empty: got deq=1 required deq=0");
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            sender_empty_n  = 1'b0;
            receiver_full_n = 1'b1;
            #1;
            sample();
            @(negedge clk);
        end
    endtask

    // Drives words base..base+n-1 (cfg_a before word chg, cfg_b after) and
    // runs until all are dequeued and the expected queue has drained.
    task automatic run_words(input int cfg_a, input int cfg_b, input int chg,
                             input int base, input int n, input int stall,
                             input int full, input bit chk_block);
        int idx    = 0;
        int cyc    = 0;
        int first  = -1;
        int last   = -1;
        int groups = 0;
        int e0     = enq_seen;
        int fc     = clampf(cfg_a);
        bit ok_blk = 1'b1;
        while (((idx < n) || (exp_q.size() != 0)) && (cyc < BUDGET)) begin
            cfg_fetch_count = CW'((idx < chg) ? cfg_a : cfg_b);
            sender_empty_n  = (idx < n) && (int'($urandom_range(99)) >= stall);
            sender_data     = DW'(base + idx);
            receiver_full_n = (idx >= n) || (int'($urandom_range(99)) >= full);
            #1;
            if (chk_block && sender_deq && !receiver_full_n && (groups > (enq_seen - e0)))
                ok_blk = 1'b0;
            sample();
            if (sender_deq) begin
                if (first < 0) first = cyc;
                last = cyc;
                idx++;
                groups = idx / fc;
            end
            @(negedge clk);
            cyc++;
        end
        sender_empty_n  = 1'b0;
        receiver_full_n = 1'b1;
        check("stream_in_budget", 64'(cyc < BUDGET), 64'(1));
        if (chk_block) check("no_deq_while_blocked", 64'(ok_blk), 64'(1));
        if ((stall == 0) && (full == 0) && (n > 0))
            check("deq_every_cycle", 64'(last - first + 1), 64'(n));
    endtask

    initial begin
        rst             = 1'b1;
        cfg_fetch_count = CW'(2);
        sender_data     = '0;
        sender_empty_n  = 1'b1;
        receiver_full_n = 1'b1;
        flush           = 1'b0;

        // Reset state, with a pending sender word that must not be popped.
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_deq",  64'(sender_deq),    64'(0));
        check("rst_enq",  64'(receiver_enq),  64'(0));
        check("rst_data", 64'(receiver_data), 64'(0));
        check("rst_mask", 64'(receiver_mask), 64'(0));
        check("rst_busy", 64'(busy),          64'(0));
        rst            = 1'b0;
        sender_empty_n = 1'b0;
        @(negedge clk);

        // cfg, base, words, stall %, full_n-low %, expected mask
        vecs[0] = '{2, 0,  4, 0,  0,  4'b0011};
        vecs[1] = '{4, 0,  8, 50, 50, 4'b1111};
        vecs[2] = '{0, 0,  4, 0,  0,  4'b1111};
        vecs[3] = '{7, 0,  4, 0,  0,  4'b1111};
        vecs[4] = '{1, 5,  4, 0,  0,  4'b0001};
        vecs[5] = '{3, 30, 6, 30, 30, 4'b0111};

        for (int v = 0; v < 6; v++) begin
            int fc;
            fc = clampf(vecs[v].cfg);
            for (int g = 0; g < vecs[v].n / fc; g++) begin
                e      = mk(fc, vecs[v].base + g * fc);
                e.mask = vecs[v].mask;
                exp_q.push_back(e);
            end
            run_words(vecs[v].cfg, vecs[v].cfg, vecs[v].n, vecs[v].base,
                      vecs[v].n, vecs[v].stall, vecs[v].full, 1'b1);
            #1;
            check("vec_idle_busy", 64'(busy), 64'(0));
            @(negedge clk);
        end

        // Group size changes from 3 to 1 after word 1: the open group stays 3 lanes.
        exp_q.push_back(mk(3, 0));
        exp_q.push_back(mk(1, 3));
        exp_q.push_back(mk(1, 4));
        run_words(3, 1, 2, 0, 5, 0, 0, 1'b0);
        #1;
        check("cfgchg_busy", 64'(busy), 64'(0));
        @(negedge clk);

        // Flush behaviour on a half-filled 4-lane group.
        run_words(4, 4, 2, 10, 2, 0, 0, 1'b0);
        #1;
        check("partial_busy", 64'(busy), 64'(1));
        @(negedge clk);
`ifdef AGG_FLUSH_EN
        exp_q.push_back(mk(2, 10));
        flush = 1'b1;
        #1;
        sample();
        @(negedge clk);
        flush = 1'b0;
        wcyc  = 0;
        while ((exp_q.size() != 0) && (wcyc < 20)) begin
            #1;
            sample();
            @(negedge clk);
            wcyc++;
        end
        check("flush_emitted", 64'(exp_q.size()), 64'(0));
        #1;
        check("flush_after_busy", 64'(busy), 64'(0));
        @(negedge clk);
        enq0  = enq_seen;
        flush = 1'b1;
        #1;
        sample();
        @(negedge clk);
        flush = 1'b0;
        idle(6);
        check("flush_empty_no_enq", 64'(enq_seen - enq0), 64'(0));
        #1;
        check("flush_empty_busy", 64'(busy), 64'(0));
        @(negedge clk);
`else
        enq0  = enq_seen;
        flush = 1'b1;
        #1;
        sample();
        @(negedge clk);
        flush = 1'b0;
        idle(6);
        check("flush_ignored_no_enq", 64'(enq_seen - enq0), 64'(0));
        #1;
        check("flush_ignored_busy", 64'(busy), 64'(1));
        @(negedge clk);
        exp_q.push_back(mk(4, 10));
        run_words(4, 4, 2, 12, 2, 0, 0, 1'b0);
        #1;
        check("flush_ignored_done", 64'(busy), 64'(0));
        @(negedge clk);
`endif

        // Reset in the middle of a group discards it.
        run_words(4, 4, 2, 20, 2, 0, 0, 1'b0);
        #1;
        check("pre_rst_busy", 64'(busy), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_enq", 64'(receiver_enq), 64'(0));
        sample();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_mask", 64'(receiver_mask), 64'(0));
        @(negedge clk);
        exp_q.push_back(mk(4, 20));
        run_words(4, 4, 4, 20, 4, 0, 0, 1'b0);
        #1;
        check("post_rst_done", 64'(busy), 64'(0));
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
